// File: rtl/byte_logic_sequencer_pkg.sv
// Shared types and constants for the byte logic sequencer.
// Opcode encodings, FSM state enum and default widths.
package byte_logic_sequencer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  localparam logic [2:0] OP_OR   = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    S_OP  = 2'd0,
    S_A   = 2'd1,
    S_B   = 2'd2,
    S_OUT = 2'd3
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_XNOR;
  endfunction

endpackage

// File: rtl/byte_logic_sequencer_unit.sv
// Combinational byte logic unit: f(op, a, b) from per-bit gates.
// Inverted variants reuse the plain OR/AND/XOR byte paths.
module byte_logic_unit
  import byte_logic_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] or_y;
  logic [WIDTH-1:0] and_y;
  logic [WIDTH-1:0] xor_y;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign or_y[i]  = a[i] | b[i];
    assign and_y[i] = a[i] & b[i];
    assign xor_y[i] = a[i] ^ b[i];
  end

  always_comb begin
    y = '0;
    unique case (op)
      OP_OR:   y = or_y;
      OP_NOR:  y = ~or_y;
      OP_AND:  y = and_y;
      OP_NAND: y = ~and_y;
      OP_XOR:  y = xor_y;
      OP_XNOR: y = ~xor_y;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/byte_logic_sequencer.sv
// Frame sequencer: collects opcode/A/B bytes, registers the logic
// result and hands it downstream with op counter and sticky err.
module byte_logic_sequencer
  import byte_logic_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_op,
  input  logic             clr_err,
  output logic             err,
  output logic [CNT_W-1:0] op_count
);

  state_e           state_q, state_d;
  logic [2:0]       opcode_q, opcode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [2:0]       out_op_q, out_op_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] lu_y;

  byte_logic_unit #(
    .WIDTH(WIDTH)
  ) u_lu (
    .op(opcode_q),
    .a (a_q),
    .b (in_data),
    .y (lu_y)
  );

  assign in_ready  = (state_q != S_OUT);
  assign out_valid = (state_q == S_OUT);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    a_d        = a_q;
    out_data_d = out_data_q;
    out_op_d   = out_op_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    if (clr_err) err_d = 1'b0;
    unique case (state_q)
      S_OP: if (in_fire) begin
        opcode_d = in_data[2:0];
        state_d  = S_A;
      end
      S_A: if (in_fire) begin
        a_d     = in_data;
        state_d = S_B;
      end
      S_B: if (in_fire) begin
        out_data_d = lu_y;
        out_op_d   = opcode_q;
        // set beats a coincident clear
        if (!op_legal(opcode_q)) err_d = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: if (out_fire) begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_OP;
      end
      default: state_d = S_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_OP;
      opcode_q   <= '0;
      a_q        <= '0;
      out_data_q <= '0;
      out_op_q   <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      a_q        <= a_d;
      out_data_q <= out_data_d;
      out_op_q   <= out_op_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_data = out_data_q;
  assign out_op   = out_op_q;
  assign err      = err_q;
  assign op_count = cnt_q;

endmodule
